// File: rtl/photon_emu_pkg.sv
// Shared constants, field map and random-mode state encoding for the
// photon emulator.
package photon_emu_pkg;

  localparam logic [1:0] FLD_CTRL   = 2'd0;
  localparam logic [1:0] FLD_PERIOD = 2'd1;
  localparam logic [1:0] FLD_WIDTH  = 2'd2;
  localparam logic [1:0] FLD_THRESH = 2'd3;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_RAND = 1;
  localparam int CTRL_CLR  = 2;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    RS_IDLE = 2'd0,
    RS_HIGH = 2'd1,
    RS_DEAD = 2'd2
  } rnd_state_e;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/photon_emu_channel.sv
// One emulated detector channel: config/shadow registers, periodic phase
// counter, random IDLE/HIGH/DEAD machine, LFSR and saturating pulse counter.
module photon_emu_channel
  import photon_emu_pkg::*;
#(
  parameter int          CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'h0001
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_run,
  input  logic             i_wr,
  input  logic [1:0]       i_field,
  input  logic [CNT_W-1:0] i_data,
  output logic [CNT_W-1:0] o_rd_val,
  output logic             o_det
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic             r_en, r_rand;
  logic [CNT_W-1:0] r_period_sh, r_width_sh, r_period, r_width, r_thresh;
  logic [CNT_W-1:0] r_phase, r_cnt;
  logic [15:0]      r_lfsr;
  logic             r_det;
  rnd_state_e       r_state;

  logic             w_wr_ctrl, w_wr_per, w_wr_wid, w_wr_thr;
  logic [CNT_W-1:0] w_per_sh_nxt, w_wid_sh_nxt;
  logic             w_active, w_wrap, w_rnd_hit;
  logic [CNT_W-1:0] w_eff_w, w_rnd_w;
  rnd_state_e       w_state_nxt;
  logic [CNT_W-1:0] w_phase_nxt;
  logic             w_det_nxt, w_lfsr_step, w_boundary, w_rise, w_clr;

  assign w_wr_ctrl = i_wr & (i_field == FLD_CTRL);
  assign w_wr_per  = i_wr & (i_field == FLD_PERIOD);
  assign w_wr_wid  = i_wr & (i_field == FLD_WIDTH);
  assign w_wr_thr  = i_wr & (i_field == FLD_THRESH);
  assign w_clr     = w_wr_ctrl & i_data[CTRL_CLR];

  // Forward same-cycle writes so an idle channel picks them up immediately.
  assign w_per_sh_nxt = w_wr_per ? i_data : r_period_sh;
  assign w_wid_sh_nxt = w_wr_wid ? i_data : r_width_sh;

  assign w_active  = i_run & r_en & (r_period != '0);
  assign w_wrap    = (r_phase == r_period - ONE);
  assign w_eff_w   = (r_width >= r_period) ? r_period - ONE : r_width;
  assign w_rnd_w   = (r_width == '0) ? ONE : r_width;
  assign w_rnd_hit = (CNT_W'(r_lfsr) < r_thresh);

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_det_nxt   = 1'b0;
    w_lfsr_step = 1'b0;
    w_boundary  = 1'b0;
    if (!w_active) begin
      w_state_nxt = RS_IDLE;
      w_phase_nxt = '0;
      w_boundary  = 1'b1;
    end else if (!r_rand) begin
      w_state_nxt = RS_IDLE;
      w_det_nxt   = (r_phase < w_eff_w);
      if (w_wrap) begin
        w_phase_nxt = '0;
        w_boundary  = 1'b1;
      end else begin
        w_phase_nxt = r_phase + ONE;
      end
    end else begin
      // In random mode the phase counter counts HIGH cycles, then DEAD cycles.
      case (r_state)
        RS_IDLE: begin
          w_boundary  = 1'b1;
          w_lfsr_step = 1'b1;
          if (w_rnd_hit) begin
            w_state_nxt = RS_HIGH;
            w_phase_nxt = ONE;
            w_det_nxt   = 1'b1;
          end
        end
        RS_HIGH: begin
          if (r_phase >= w_rnd_w) begin
            w_state_nxt = RS_DEAD;
            w_phase_nxt = '0;
          end else begin
            w_det_nxt   = 1'b1;
            w_phase_nxt = r_phase + ONE;
          end
        end
        RS_DEAD: begin
          if (w_wrap) begin
            w_state_nxt = RS_IDLE;
            w_phase_nxt = '0;
          end else begin
            w_phase_nxt = r_phase + ONE;
          end
        end
        default: begin
          w_state_nxt = RS_IDLE;
          w_phase_nxt = '0;
        end
      endcase
    end
  end

  assign w_rise = w_det_nxt & ~r_det;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RS_IDLE;
      r_phase <= '0;
      r_det   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_det   <= w_det_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en        <= 1'b0;
      r_rand      <= 1'b0;
      r_period_sh <= '0;
      r_width_sh  <= '0;
      r_period    <= '0;
      r_width     <= '0;
      r_thresh    <= '0;
      r_lfsr      <= LFSR_SEED;
      r_cnt       <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_en   <= i_data[CTRL_EN];
        r_rand <= i_data[CTRL_RAND];
      end
      r_period_sh <= w_per_sh_nxt;
      r_width_sh  <= w_wid_sh_nxt;
      if (w_wr_thr) r_thresh <= i_data;
      if (w_boundary) begin
        r_period <= w_per_sh_nxt;
        r_width  <= w_wid_sh_nxt;
      end
      if (w_lfsr_step) r_lfsr <= lfsr_step(r_lfsr);
      if (w_clr) r_cnt <= '0;
      else if (w_rise && (r_cnt != '1)) r_cnt <= r_cnt + ONE;
    end
  end

  always_comb begin
    o_rd_val = '0;
    case (i_field)
      FLD_CTRL: begin
        o_rd_val[CTRL_EN]   = r_en;
        o_rd_val[CTRL_RAND] = r_rand;
      end
      FLD_PERIOD: o_rd_val = r_period_sh;
      FLD_WIDTH:  o_rd_val = r_width_sh;
      default:    o_rd_val = r_cnt;
    endcase
  end

  assign o_det = r_det;

endmodule

// File: rtl/photon_emulator.sv
// N-channel detector-pulse emulator top: channel address decode, per-channel
// instances and the registered read port.
module photon_emulator
  import photon_emu_pkg::*;
#(
  parameter int          N_CH  = 4,
  parameter int          CNT_W = 16,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             cfg_wr,
  input  logic             cfg_rd,
  input  logic [5:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_data,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_valid,
  output logic [N_CH-1:0]  det_out
);

  logic [3:0]                  w_ch;
  logic [1:0]                  w_fld;
  logic [N_CH-1:0]             w_wr;
  logic [N_CH-1:0][CNT_W-1:0]  w_rd_val;
  logic [CNT_W-1:0]            w_rd_mux;
  logic [CNT_W-1:0]            r_rd_data;
  logic                        r_rd_valid;

  assign w_ch  = cfg_addr[5:2];
  assign w_fld = cfg_addr[1:0];

  // Channel numbers at or above N_CH match no instance, so writes drop out.
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign w_wr[k] = cfg_wr & (w_ch == 4'(k));
    photon_emu_channel #(
      .CNT_W     (CNT_W),
      .LFSR_SEED (SEED ^ 16'(k + 1))
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_run    (run),
      .i_wr     (w_wr[k]),
      .i_field  (w_fld),
      .i_data   (cfg_data),
      .o_rd_val (w_rd_val[k]),
      .o_det    (det_out[k])
    );
  end

  always_comb begin
    w_rd_mux = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (w_ch == 4'(k)) w_rd_mux = w_rd_val[k];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= cfg_rd;
      if (cfg_rd) r_rd_data <= w_rd_mux;
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_photon_emulator.sv
// Directed bench for photon_emulator: periodic, clamp, shadow, random,
// stop/clear and address-edge behaviour.
module tb_photon_emulator;

  localparam int N_CH  = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             run = 1'b0;
  logic             cfg_wr = 1'b0;
  logic             cfg_rd = 1'b0;
  logic [5:0]       cfg_addr = '0;
  logic [CNT_W-1:0] cfg_data = '0;
  logic [CNT_W-1:0] rd_data;
  logic             rd_valid;
  logic [N_CH-1:0]  det_out;

  int vectors = 0;
  int miscmp  = 0;

  photon_emulator #(.N_CH(N_CH), .CNT_W(CNT_W), .SEED(16'hACE1)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (run),
    .cfg_wr   (cfg_wr),
    .cfg_rd   (cfg_rd),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .det_out  (det_out)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int ch, input logic [1:0] fld, input logic [15:0] d);
    cfg_addr = {4'(ch), fld};
    cfg_data = d;
    cfg_wr   = 1'b1;
    tick();
    cfg_wr   = 1'b0;
  endtask

  task automatic rd(input int ch, input logic [1:0] fld, output logic [15:0] v);
    cfg_addr = {4'(ch), fld};
    cfg_rd   = 1'b1;
    tick();
    cfg_rd   = 1'b0;
    v = rd_data;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    run     = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic cfg_rand_ch1();
    wr(1, 2'd1, 16'd8);
    wr(1, 2'd2, 16'd3);
    wr(1, 2'd3, 16'h1000);
    wr(1, 2'd0, 16'd3);
  endtask

  initial begin
    logic [15:0] v;
    int bad, rises, bad_w, bad_gap, hi_len, lo_len, lo, hi;
    bit prev, have_pulse, d;
    int t1 [4];
    int t2 [4];
    int n1, n2;

    // Reset state
    tick(2);
    check("rst_det", 32'(det_out), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    reset_n = 1'b1;
    tick();
    rd(0, 2'd1, v);
    check("rst_period_field", 32'(v), 32'd0);

    // Periodic: PERIOD=25 WIDTH=2
    wr(0, 2'd1, 16'd25);
    wr(0, 2'd2, 16'd2);
    wr(0, 2'd0, 16'd1);
    run = 1'b1;
    check("per_pre_run_low", 32'(det_out[0]), 32'd0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (i == 0) check("per_first_high", 32'(det_out[0]), 32'd1);
      if (det_out[0] !== ((i % 25) < 2)) bad++;
    end
    check("per_pattern", 32'(bad), 32'd0);
    run = 1'b0;
    rd(0, 2'd3, v);
    check("per_count", 32'(v), 32'd4);
    check("per_stop_low", 32'(det_out[0]), 32'd0);

    // Clamp: PERIOD=4 WIDTH=9 -> 3 high, 1 low
    wr(0, 2'd1, 16'd4);
    wr(0, 2'd2, 16'd9);
    run = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (det_out[0] !== ((i % 4) < 3)) bad++;
    end
    check("clamp_pattern", 32'(bad), 32'd0);
    run = 1'b0;
    tick();

    // PERIOD=0 never fires
    wr(0, 2'd1, 16'd0);
    run = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (det_out[0] !== 1'b0) bad++;
    end
    check("period0_low", 32'(bad), 32'd0);
    run = 1'b0;

    // THRESH=0 random never fires
    wr(1, 2'd1, 16'd8);
    wr(1, 2'd2, 16'd3);
    wr(1, 2'd3, 16'd0);
    wr(1, 2'd0, 16'd3);
    run = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (det_out[1] !== 1'b0) bad++;
    end
    check("thresh0_low", 32'(bad), 32'd0);
    run = 1'b0;
    wr(1, 2'd0, 16'd0);

    // Shadow: PERIOD 20 -> 10 written at phase 5
    wr(0, 2'd2, 16'd2);
    wr(0, 2'd1, 16'd20);
    run = 1'b1;
    bad = 0;
    for (int i = 0; i < 46; i++) begin
      if (i == 5) begin
        cfg_addr = {4'd0, 2'd1};
        cfg_data = 16'd10;
        cfg_wr   = 1'b1;
      end
      tick();
      cfg_wr = 1'b0;
      if (det_out[0] !== ((i < 20) ? (i < 2) : (((i - 20) % 10) < 2))) bad++;
    end
    check("shadow_pattern", 32'(bad), 32'd0);
    run = 1'b0;
    rd(0, 2'd1, v);
    check("shadow_readback", 32'(v), 32'd10);

    // Random: long run from reset
    do_reset();
    cfg_rand_ch1();
    run = 1'b1;
    rises = 0; bad_w = 0; bad_gap = 0; hi_len = 0; lo_len = 0;
    prev = 1'b0; have_pulse = 1'b0; n1 = 0;
    for (int c = 0; c < 65536; c++) begin
      tick();
      d = det_out[1];
      if (d && !prev) begin
        rises++;
        if (n1 < 4) begin t1[n1] = c; n1++; end
        if (have_pulse && lo_len < 9) bad_gap++;
        hi_len = 1;
      end else if (d) begin
        hi_len++;
      end else if (prev) begin
        if (hi_len != 3) bad_w++;
        lo_len = 1;
        have_pulse = 1'b1;
      end else begin
        lo_len++;
      end
      prev = d;
    end
    run = 1'b0;
    rd(1, 2'd3, v);
    check("rand_width", 32'(bad_w), 32'd0);
    check("rand_gap", 32'(bad_gap), 32'd0);
    lo = (65536 / 27) * 8 / 10;
    hi = (65536 / 27) * 12 / 10;
    check("rand_rate", 32'((rises >= lo) && (rises <= hi)), 32'd1);
    check("rand_counter", 32'(v), 32'(rises));

    // Random: repeatability after reset
    do_reset();
    cfg_rand_ch1();
    run = 1'b1;
    prev = 1'b0; n2 = 0;
    for (int c = 0; c < 600; c++) begin
      tick();
      if (det_out[1] && !prev && n2 < 4) begin t2[n2] = c; n2++; end
      prev = det_out[1];
    end
    run = 1'b0;
    bad = 0;
    for (int k = 0; k < 4; k++) if (k < n1 && k < n2 && t1[k] != t2[k]) bad++;
    check("rand_repeat_n", 32'(n2), 32'(n1));
    check("rand_repeat_t", 32'(bad), 32'd0);
    wr(1, 2'd0, 16'd0);

    // Stop mid-pulse and counter clear
    wr(0, 2'd1, 16'd10);
    wr(0, 2'd2, 16'd5);
    wr(0, 2'd0, 16'd1);
    run = 1'b1;
    tick(2);
    check("stop_mid_high", 32'(det_out[0]), 32'd1);
    run = 1'b0;
    tick();
    check("stop_low", 32'(det_out[0]), 32'd0);
    rd(0, 2'd3, v);
    check("stop_count_kept", 32'(v), 32'd1);
    run = 1'b1;
    tick();
    wr(0, 2'd0, 16'd5);
    check("clr_still_high", 32'(det_out[0]), 32'd1);
    rd(0, 2'd3, v);
    check("clr_count", 32'(v), 32'd0);
    run = 1'b0;
    tick();
    run = 1'b1;
    wr(0, 2'd0, 16'd5);
    check("clr_vs_inc_high", 32'(det_out[0]), 32'd1);
    rd(0, 2'd3, v);
    check("clr_wins", 32'(v), 32'd0);
    run = 1'b0;
    tick();

    // Address edges
    wr(5, 2'd1, 16'h0055);
    rd(5, 2'd1, v);
    check("oob_read", 32'(v), 32'd0);
    check("oob_rd_valid", 32'(rd_valid), 32'd1);
    tick();
    check("rd_valid_pulse", 32'(rd_valid), 32'd0);
    rd(1, 2'd1, v);
    check("oob_no_alias_ch1", 32'(v), 32'd8);
    rd(0, 2'd1, v);
    check("oob_ch0_period", 32'(v), 32'd10);
    rd(1, 2'd0, v);
    check("ctrl_read", 32'(v), 32'd0);
    cfg_addr = {4'd0, 2'd2};
    cfg_data = 16'd7;
    cfg_wr   = 1'b1;
    cfg_rd   = 1'b1;
    tick();
    cfg_wr = 1'b0;
    cfg_rd = 1'b0;
    check("wr_rd_old", 32'(rd_data), 32'd5);
    check("wr_rd_valid", 32'(rd_valid), 32'd1);
    tick();
    check("wr_rd_valid_drop", 32'(rd_valid), 32'd0);
    rd(0, 2'd2, v);
    check("wr_rd_new", 32'(v), 32'd7);

    // Asynchronous reset mid-pulse
    run = 1'b1;
    tick();
    check("arst_pre_high", 32'(det_out[0]), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_det_low", 32'(det_out), 32'd0);
    run = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    rd(0, 2'd2, v);
    check("arst_fields_cleared", 32'(v), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
    $finish;
  end

endmodule

// File: doc/photon_emulator.md
# photon_emulator

Synthesisable N-channel detector-pulse emulator. It replaces the hand-written detector stimulus used in simulation, so the same periodic and random photon patterns can drive the timetagger's detector inputs in hardware loopback and bench runs. It sits beside the timetagger core in the `clk` domain and feeds its `detectors` inputs through a mux. It is configured through the same register-write path that the FX2 command decoder already drives.

## Interface
Parameters:
- `N_CH`, 4: number of emulated detector channels (1–16).
- `CNT_W`, 16: width of the period, width and threshold fields, and of the pulse counters.
- `SEED`, 16'hACE1: base LFSR seed. Channel k uses `SEED ^ (k+1)`, which is never zero.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous active-low reset.
- `run` in 1: global enable. Channels only emit pulses while `run`=1.
- `cfg_wr` in 1: one-cycle register write strobe.
- `cfg_rd` in 1: one-cycle register read strobe.
- `cfg_addr` in 6: {channel[3:0], field[1:0]}.
- `cfg_data` in CNT_W: write data.
- `rd_data` out CNT_W: read data.
- `rd_valid` out 1: read data valid.
- `det_out` out N_CH: emulated detector pulses, registered.

## Operation
- Per-channel fields:
  - 0 `CTRL`: bit0 `en`, bit1 `rand`; writing bit2=1 clears the pulse counter.
  - 1 `PERIOD`: period in periodic mode; minimum dead time in random mode.
  - 2 `WIDTH`: pulse high time in cycles.
  - 3 `THRESH`: random firing threshold on write; the pulse counter on read.
- Writes to channel ≥ `N_CH` are ignored. Reads from channel ≥ `N_CH` return 0.
- `CTRL` takes effect on the next cycle.
- `PERIOD` and `WIDTH` go into shadow registers. They are copied to the active set at the next period boundary, or immediately if the channel is idle (`run`=0 or `en`=0).
- A channel is active when `run`=1, `en`=1 and `PERIOD`≠0. An inactive channel holds `det_out`=0 and keeps its phase counter at 0.
- Periodic mode (`rand`=0):
  - Phase counter runs 0..PERIOD−1 and wraps.
  - `det_out` is high while phase < WIDTH.
  - If WIDTH ≥ PERIOD, the effective width is PERIOD−1, so every period still has a rising edge.
  - If PERIOD=1, the output stays low.
- Random mode (`rand`=1), states IDLE → HIGH → DEAD:
  - IDLE: each cycle the channel steps its 16-bit Galois LFSR (taps 0xB400). If `lfsr[CNT_W-1:0]` < THRESH, it goes to HIGH.
  - HIGH: `det_out` stays high for WIDTH cycles (at least 1), then goes to DEAD.
  - DEAD: waits PERIOD cycles, then returns to IDLE.
  - THRESH=0 means the channel never fires.
  - The LFSR advances only in IDLE while the channel is active.
- Pulse counter:
  - Increments on each `det_out` rising edge and saturates at all-ones.
  - If a clear and an increment land in the same cycle, the clear wins.
- Reads: `rd_data` and `rd_valid` are registered one cycle after `cfg_rd`. If `cfg_wr` and `cfg_rd` coincide on the same address, the read returns the old value.
- Deasserting `run` mid-pulse forces `det_out` low on the next cycle and returns the FSM to IDLE. LFSR state and counters are kept.

## Timing
- Reset values: `det_out`=0, `rd_data`=0, `rd_valid`=0, all fields 0, LFSRs at their seeds.
- Latency from `run` rising (channel active, periodic) to `det_out` high: 1 cycle.
- Latency from an IDLE hit to `det_out` high: 1 cycle.
- Read latency: 1 cycle.
- Minimum random-mode pulse spacing: WIDTH+PERIOD+1 cycles.
- Assertion of `reset_n` mid-pulse clears everything asynchronously. Deassertion must be synchronised externally.

## Structure
- `photon_emu_pkg` holds the field address constants, `LFSR_TAPS`, the `CTRL` bit positions and the random FSM state enum.
- Sub-module `photon_emu_channel` holds one channel's registers, shadows, phase counter, FSM, LFSR and pulse counter. It is instantiated `N_CH` times by a generate loop.
- The top level does address decode and the registered read mux only.

## Test plan
- Periodic: ch0 PERIOD=25, WIDTH=2, en=1, run=1 → `det_out[0]` high 2 of every 25 cycles, first high 1 cycle after `run`. Counter reads 4 after 100 cycles.
- Clamp and zero cases:
  - PERIOD=4, WIDTH=9 → output high 3 cycles, low 1 cycle, repeating.
  - PERIOD=0 → output stays low.
  - THRESH=0 with rand=1 → output stays low.
- Shadow update: with PERIOD=20 running, write PERIOD=10 at phase 5 → the current period completes at 20 cycles, then the period is 10.
- Random: ch1 rand=1, THRESH=16'h1000, WIDTH=3, PERIOD=8 →
  - every pulse is exactly 3 cycles and every gap is at least 9 cycles;
  - over 64k cycles the pulse count is within ±20% of the expected rate;
  - the pulse sequence is identical after reset.
- Stop mid-pulse: deassert `run` during a high cycle → `det_out` is 0 on the next cycle and the counter is unchanged. Counter clear while pulsing → reads 0 on the next read.
- Address edges: writing channel 5 with `N_CH`=4 changes nothing and a read returns 0. Simultaneous write and read on the same address returns the old value, and `rd_valid` is a 1-cycle pulse.
